// File: rtl/alu_hs_if.sv
// rtl/alu_hs_if.sv - operand/result handshake bundle for the fixed-point ALU
interface alu_hs_if #(
  parameter int DATA_W = 16,
  parameter int INST_W = 4
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data_a;
  logic [DATA_W-1:0] i_data_b;
  logic [INST_W-1:0] i_inst;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_ovf;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_inst, i_ready,
    output o_ready, o_valid, o_data, o_ovf
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_inst, i_ready,
    input  o_ready, o_valid, o_data, o_ovf
  );
endinterface

// File: rtl/alu_hs.sv
// rtl/alu_hs.sv - valid/ready fixed-point ALU with saturation, MAC and iterative LRCW/LFSR
module alu_hs #(
  parameter int INT_W  = 6,
  parameter int FRAC_W = 10,
  parameter int INST_W = 4,
  parameter int DATA_W = INT_W + FRAC_W,
  parameter int CNT_W  = $clog2(DATA_W) + 1,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic     i_clk,
  input  logic     i_rst,
  alu_hs_if.slave  bus
);
  localparam int WW = 2 * DATA_W + 1;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [WW-1:0] WMAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] WMIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [WW-1:0] RND  = WW'(2 ** (FRAC_W - 1));

  localparam logic [INST_W-1:0] OP_ADD  = INST_W'(0);
  localparam logic [INST_W-1:0] OP_SUB  = INST_W'(1);
  localparam logic [INST_W-1:0] OP_MUL  = INST_W'(2);
  localparam logic [INST_W-1:0] OP_MAC  = INST_W'(3);
  localparam logic [INST_W-1:0] OP_MACC = INST_W'(4);
  localparam logic [INST_W-1:0] OP_CLZ  = INST_W'(5);
  localparam logic [INST_W-1:0] OP_LRCW = INST_W'(6);
  localparam logic [INST_W-1:0] OP_LFSR = INST_W'(7);
  localparam logic [INST_W-1:0] OP_MIN  = INST_W'(8);
  localparam logic [INST_W-1:0] OP_MAX  = INST_W'(9);
  localparam logic [INST_W-1:0] OP_ABS  = INST_W'(10);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

  state_t            state;
  logic              ready_q, valid_q, ovf_q, lfsr_q;
  logic [DATA_W-1:0] data_q, a_q, b_q, acc_q, w_q;
  logic [INST_W-1:0] inst_q;
  logic [CNT_W-1:0]  cnt_q;

  // Sign-extend an operand into the wide arithmetic domain.
  function automatic logic signed [WW-1:0] sx(input logic [DATA_W-1:0] v);
    return {{(DATA_W+1){v[DATA_W-1]}}, v};
  endfunction

  // Clamp a wide value into DATA_W; top bit of the return is the clamp flag.
  function automatic logic [DATA_W:0] sat(input logic signed [WW-1:0] v);
    if (v > WMAX)      return {1'b1, SAT_MAX};
    else if (v < WMIN) return {1'b1, SAT_MIN};
    else               return {1'b0, v[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] clz(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] n;
    logic seen;
    n = '0;
    seen = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      else if (!seen) n = n + DATA_W'(1);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) n = n + CNT_W'(1);
    end
    return n;
  endfunction

  logic signed [WW-1:0] prod_w, rnd_w, mul_w, add_w, sub_w, mac_w;
  logic [DATA_W:0]      add_s, sub_s, mul_s, mac_s;
  logic [DATA_W-1:0]    ex_res, ex_w, w_next;
  logic                 ex_ovf, ex_acc_wr, ex_iter, ex_lfsr;
  logic [CNT_W-1:0]     ex_n;

  // Datapath for the EXEC cycle, operating on the latched operands.
  always_comb begin
    add_w  = sx(a_q) + sx(b_q);
    sub_w  = sx(a_q) - sx(b_q);
    prod_w = sx(a_q) * sx(b_q);
    rnd_w  = prod_w + RND;
    mul_w  = rnd_w >>> FRAC_W;
    add_s  = sat(add_w);
    sub_s  = sat(sub_w);
    mul_s  = sat(mul_w);
    mac_w  = sx(acc_q) + sx(mul_s[DATA_W-1:0]);
    mac_s  = sat(mac_w);

    ex_res    = '0;
    ex_ovf    = 1'b0;
    ex_acc_wr = 1'b0;
    ex_iter   = 1'b0;
    ex_lfsr   = 1'b0;
    ex_w      = '0;
    ex_n      = '0;
    case (inst_q)
      OP_ADD:  {ex_ovf, ex_res} = add_s;
      OP_SUB:  {ex_ovf, ex_res} = sub_s;
      OP_MUL:  {ex_ovf, ex_res} = mul_s;
      OP_MAC: begin
        ex_res    = mac_s[DATA_W-1:0];
        ex_ovf    = mac_s[DATA_W] | mul_s[DATA_W];
        ex_acc_wr = 1'b1;
      end
      OP_MACC: begin
        {ex_ovf, ex_res} = mul_s;
        ex_acc_wr = 1'b1;
      end
      OP_CLZ:  ex_res = clz(a_q);
      OP_LRCW: begin
        ex_iter = 1'b1;
        ex_w    = b_q;
        ex_n    = popcount(a_q);
      end
      OP_LFSR: begin
        ex_iter = 1'b1;
        ex_lfsr = 1'b1;
        ex_w    = a_q;
        ex_n    = b_q[CNT_W-1:0];
      end
      OP_MIN:  ex_res = ($signed(a_q) < $signed(b_q)) ? a_q : b_q;
      OP_MAX:  ex_res = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
      OP_ABS: begin
        if (a_q == SAT_MIN) begin
          ex_res = SAT_MAX;
          ex_ovf = 1'b1;
        end else begin
          ex_res = a_q[DATA_W-1] ? (~a_q + DATA_W'(1)) : a_q;
        end
      end
      default: ex_res = '0;
    endcase

    w_next = lfsr_q ? {w_q[DATA_W-2:0], ^(w_q & LFSR_TAPS)}
                    : {w_q[DATA_W-2:0], ~w_q[DATA_W-1]};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      lfsr_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      inst_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_valid && ready_q) begin
            a_q     <= bus.i_data_a;
            b_q     <= bus.i_data_b;
            inst_q  <= bus.i_inst;
            ready_q <= 1'b0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ex_iter) begin
            w_q    <= ex_w;
            cnt_q  <= ex_n;
            lfsr_q <= ex_lfsr;
            if (ex_n == '0) begin
              data_q  <= ex_w;
              ovf_q   <= 1'b0;
              valid_q <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_ITER;
            end
          end else begin
            data_q  <= ex_res;
            ovf_q   <= ex_ovf;
            valid_q <= 1'b1;
            if (ex_acc_wr) acc_q <= ex_res;
            state <= S_DONE;
          end
        end
        S_ITER: begin
          // The final step's value goes straight to the output register.
          w_q   <= w_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            data_q  <= w_next;
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_alu_hs.sv
// tb/tb_alu_hs.sv - directed self-checking bench for alu_hs
module tb_alu_hs;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_hs_if #(.DATA_W(16), .INST_W(4)) bus ();

  alu_hs dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue one op with i_ready high and check result, flag and latency.
  task automatic run_op(input string tag, input logic [3:0] inst, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_d, input logic exp_o,
                        input int exp_lat);
    int lat;
    bus.i_valid  = 1'b1;
    bus.i_inst   = inst;
    bus.i_data_a = a;
    bus.i_data_b = b;
    tick();
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " data"}, bus.o_data, exp_d);
    check({tag, " ovf"}, bus.o_ovf, exp_o);
    tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;
    bus.i_inst   = '0;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    #1;
    do_reset();

    check("rst o_valid", bus.o_valid, 1'b0);
    check("rst o_data", bus.o_data, 16'h0000);
    check("rst o_ovf", bus.o_ovf, 1'b0);
    check("rst o_ready", bus.o_ready, 1'b1);

    run_op("add sat",  4'd0,  16'h7C00, 16'h0800, 16'h7FFF, 1'b1, 2);
    run_op("sub",      4'd1,  16'h0400, 16'h0C00, 16'hF800, 1'b0, 2);
    run_op("mul neg",  4'd2,  16'h0600, 16'hFA00, 16'hF700, 1'b0, 2);
    run_op("mul sat",  4'd2,  16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 2);
    run_op("macc",     4'd4,  16'h0400, 16'h0400, 16'h0400, 1'b0, 2);
    run_op("mac 1",    4'd3,  16'h0800, 16'h0400, 16'h0C00, 1'b0, 2);
    run_op("add mid",  4'd0,  16'h0100, 16'h0100, 16'h0200, 1'b0, 2);
    run_op("mac 2",    4'd3,  16'h0400, 16'h0400, 16'h1000, 1'b0, 2);
    do_reset();
    run_op("mac rst",  4'd3,  16'h0400, 16'h0400, 16'h0400, 1'b0, 2);
    run_op("macc big", 4'd4,  16'h7C00, 16'h0400, 16'h7C00, 1'b0, 2);
    run_op("mac sat",  4'd3,  16'h0800, 16'h0400, 16'h7FFF, 1'b1, 2);

    run_op("lrcw",     4'd6,  16'h000F, 16'h8001, 16'h0017, 1'b0, 6);
    run_op("lfsr n0",  4'd7,  16'h0001, 16'h0000, 16'h0001, 1'b0, 2);
    run_op("lfsr n1",  4'd7,  16'h8000, 16'h0001, 16'h0001, 1'b0, 3);
    run_op("clz",      4'd5,  16'h0010, 16'h0000, 16'h000B, 1'b0, 2);
    run_op("clz zero", 4'd5,  16'h0000, 16'h0000, 16'h0010, 1'b0, 2);
    run_op("abs min",  4'd10, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 2);
    run_op("abs neg",  4'd10, 16'hFA00, 16'h0000, 16'h0600, 1'b0, 2);
    run_op("min",      4'd8,  16'h0400, 16'hF800, 16'hF800, 1'b0, 2);
    run_op("max",      4'd9,  16'h0400, 16'hF800, 16'h0400, 1'b0, 2);
    run_op("op e",     4'd14, 16'h1234, 16'h5678, 16'h0000, 1'b0, 2);

    // Backpressure: result must hold while i_ready is low and nothing new is taken.
    bus.i_ready  = 1'b0;
    bus.i_valid  = 1'b1;
    bus.i_inst   = 4'd0;
    bus.i_data_a = 16'h0100;
    bus.i_data_b = 16'h0200;
    tick();
    bus.i_inst   = 4'd1;
    bus.i_data_a = 16'h7000;
    bus.i_data_b = 16'h1000;
    tick();
    check("bp valid", bus.o_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp data", bus.o_data, 16'h0300);
      check("bp ready", bus.o_ready, 1'b0);
      check("bp valid hold", bus.o_valid, 1'b1);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    check("bp release valid", bus.o_valid, 1'b0);
    check("bp release ready", bus.o_ready, 1'b1);
    tick();
    check("bp no extra op", bus.o_valid, 1'b0);

    // Reset while iterating discards the pending result.
    bus.i_valid  = 1'b1;
    bus.i_inst   = 4'd6;
    bus.i_data_a = 16'hFFFF;
    bus.i_data_b = 16'h0000;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    tick();
    check("iter busy", bus.o_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort valid", bus.o_valid, 1'b0);
    check("abort data", bus.o_data, 16'h0000);
    check("abort ready", bus.o_ready, 1'b1);
    run_op("post abort", 4'd0, 16'h0400, 16'h0400, 16'h0800, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_hs.md
Name: alu_hs

Overview:
- Parametrised, handshake-driven fixed-point ALU for signed Qm.n data, clock `i_clk`, synchronous active-high reset `i_rst`.
- Replaces the fixed-width busy/valid ALU with a valid/ready interface on both sides, backpressure on the output, and saturation flagging.
- Adds rounding multiply, MAC with clear, min/max/abs, and an iterative LRCW/LFSR engine with parametrised taps and width.
- Sits between the operand sequencer and the result FIFO.

Parameters:
- INT_W, 6, integer bits including sign
- FRAC_W, 10, fraction bits
- INST_W, 4, opcode width
- DATA_W, INT_W+FRAC_W, operand/result width
- CNT_W, $clog2(DATA_W)+1, iteration-count width
- LFSR_TAPS, 16'hB400, feedback tap mask (bit i set = state bit i taps); width DATA_W

Ports:
- i_clk  in  1  clock, all logic on the rising edge
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  operand/opcode valid
- o_ready  out  1  block can accept an operation
- i_data_a  in  DATA_W  signed operand A
- i_data_b  in  DATA_W  signed operand B
- i_inst  in  INST_W  opcode
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_data  out  DATA_W  result
- o_ovf  out  1  result was saturated

Behaviour:
- One clock `i_clk`. Reset is synchronous and active-high on `i_rst`, sampled on the rising edge.
- Reset values: state IDLE, o_valid=0, o_data=0, o_ovf=0, accumulator=0, iteration counter=0.
- Reset mid-operation aborts; the pending result is discarded.
- FSM:
  - IDLE: o_ready=1. On i_valid&o_ready, latch a, b, inst → EXEC.
  - EXEC (1 cycle): compute. For single-cycle ops, register the result → DONE. For LRCW/LFSR, load the working register and counter N → ITER.
  - ITER: one step per cycle while N≠0, decrement N. At N==0, register the result → DONE. N=0 at entry means zero steps.
  - DONE: o_valid=1; o_data/o_ovf held stable until i_ready. On o_valid&i_ready → IDLE.
- o_ready is high only in IDLE. Inputs are ignored outside IDLE.
- Latency, accept edge to first o_valid cycle:
  - 2 cycles for single-cycle ops
  - 2+N cycles for LRCW/LFSR
- Throughput: one op per (latency+1) cycles with i_ready held high.
- Opcodes:
  - 0 ADD: a+b, saturate.
  - 1 SUB: a−b, saturate.
  - 2 MUL: full 2·DATA_W product, add 2^(FRAC_W−1), arithmetic shift right FRAC_W, saturate.
  - 3 MAC: sat(acc + MUL result). acc ← result when the result is registered. An intermediate MUL saturation also sets o_ovf.
  - 4 MACC: acc cleared first; result = MUL result; acc ← result.
  - 5 CLZ: leading zeros of a, 0..DATA_W (a=0 gives DATA_W), zero-extended.
  - 6 LRCW: N=popcount(a). Working reg w=b; each step w ← {w[DATA_W−2:0], ~w[DATA_W−1]}.
  - 7 LFSR: N=b[CNT_W−1:0]. w=a; each step w ← {w[DATA_W−2:0], ^(w & LFSR_TAPS)}.
  - 8 MIN and 9 MAX: signed compare.
  - 10 ABS: |a|; most-negative input gives max positive with o_ovf=1.
  - 11–15: result 0, o_ovf=0, latency 2.
- Saturation limits: max = {0,1…1}, min = {1,0…0}. o_ovf=1 only when clamping occurred; 0 for ops 5–9.
- Accumulator changes only on ops 3/4 and reset. It is unaffected by backpressure. Other ops do not modify it.
- An i_valid held during busy cycles is not consumed. The op is accepted on the first IDLE cycle.

Test Plan:
- Reset, then ADD a=0x7C00 (31.0), b=0x0800 (2.0) with i_ready=1 → o_data=0x7FFF, o_ovf=1, o_valid in 2nd cycle after accept; SUB 0x0400−0x0C00 → 0xF800, o_ovf=0.
- MUL 0x0600 (1.5) × 0xFA00 (−1.5) → 0xF700; MUL 0x7FFF×0x7FFF → 0x7FFF, o_ovf=1.
- MACC 0x0400×0x0400 → 0x0400; then MAC 0x0800×0x0400 → 0x0C00; then ADD, then MAC 0x0400×0x0400 → 0x1000 (acc unaffected by ADD); reset, MAC 0x0400×0x0400 → 0x0400.
- LRCW a=0x000F, b=0x8001 → 0x0017, first o_valid 6 cycles after accept; LFSR a=0x0001, b=0 → 0x0001 at latency 2; LFSR a=0x8000, b=1 → 0x0001.
- CLZ a=0x0010 → 0x000B; a=0 → 0x0010; ABS a=0x8000 → 0x7FFF, o_ovf=1; opcode 0xE → 0x0000.
- Backpressure: hold i_ready=0 for 5 cycles in DONE → o_data stable, o_ready=0, new i_valid not accepted. Assert i_rst during ITER → next cycle o_valid=0, o_data=0, o_ready=1.
